// File: rtl/branch_pred_resolve_pkg.sv
// Shared op codes, table defaults and branch-kind decode for the branch predictor/resolver.
package branch_pred_resolve_pkg;

  // ALU op codes seen at the resolve stage (same encodings as the decode-stage defines).
  localparam logic [7:0] EXE_BEQ_OP    = 8'b0101_0001;
  localparam logic [7:0] EXE_BNE_OP    = 8'b0101_0010;
  localparam logic [7:0] EXE_BLEZ_OP   = 8'b0101_0011;
  localparam logic [7:0] EXE_BGTZ_OP   = 8'b0101_0100;
  localparam logic [7:0] EXE_BLTZ_OP   = 8'b0100_0000;
  localparam logic [7:0] EXE_BGEZ_OP   = 8'b0100_0001;
  localparam logic [7:0] EXE_BLTZAL_OP = 8'b0100_1010;
  localparam logic [7:0] EXE_BGEZAL_OP = 8'b0100_1011;
  localparam logic [7:0] EXE_ADD_OP    = 8'b0010_0000;

  // Default predictor geometry.
  localparam int unsigned BP_IDX_W = 6;
  localparam int unsigned BP_CTR_W = 2;

  // Condition class of a conditional branch; linking variants share their base condition.
  typedef enum logic [2:0] {
    BrNone,
    BrEq,
    BrNe,
    BrGtz,
    BrLez,
    BrGez,
    BrLtz
  } br_kind_e;

  function automatic br_kind_e decode_br(input logic [7:0] op);
    br_kind_e kind;
    case (op)
      EXE_BEQ_OP:                  kind = BrEq;
      EXE_BNE_OP:                  kind = BrNe;
      EXE_BGTZ_OP:                 kind = BrGtz;
      EXE_BLEZ_OP:                 kind = BrLez;
      EXE_BGEZ_OP, EXE_BGEZAL_OP:  kind = BrGez;
      EXE_BLTZ_OP, EXE_BLTZAL_OP:  kind = BrLtz;
      default:                     kind = BrNone;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Up/down saturating counter; one table entry of the branch predictor.
module bp_sat_counter #(
  parameter int unsigned CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CTR_W-1:0] ctr
);

  // Weakly not-taken: MSB clear, all lower bits set.
  localparam logic [CTR_W-1:0] RstVal = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0] MaxVal = '1;

  // Count up on inc, down on dec, holding at either end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr <= RstVal;
    end else if (inc) begin
      if (ctr != MaxVal) ctr <= ctr + CTR_W'(1);
    end else if (dec) begin
      if (ctr != '0) ctr <= ctr - CTR_W'(1);
    end
  end

endmodule

// File: rtl/branch_pred_resolve.sv
// Branch predictor table (bimodal or gshare) with resolve-stage condition evaluation,
// mispredict detection, table training and a saturating mispredict counter.
module branch_pred_resolve
  import branch_pred_resolve_pkg::*;
#(
  parameter int unsigned IDX_W  = BP_IDX_W,
  parameter int unsigned CTR_W  = BP_CTR_W,
  parameter bit          GSHARE = 1'b0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  // fetch-side lookup
  input  logic [31:0]      f_pc,
  output logic             f_pred_taken,
  output logic [IDX_W-1:0] f_pred_idx,
  // resolve-side evaluation and update
  input  logic             r_valid,
  input  logic [7:0]       r_op,
  input  logic [31:0]      r_a,
  input  logic [31:0]      r_b,
  input  logic             r_pred_taken,
  input  logic [IDX_W-1:0] r_pred_idx,
  output logic             r_is_branch,
  output logic             r_taken,
  output logic             r_mispredict,
  output logic [IDX_W-1:0] ghr,
  // statistics
  input  logic             mp_cnt_clr,
  output logic [CNT_W-1:0] mp_count
);

  localparam int unsigned Depth = 2 ** IDX_W;

  logic [CTR_W-1:0] ctr_tbl [Depth];
  logic [IDX_W-1:0] ghr_q;
  logic [CNT_W-1:0] mp_count_q;
  br_kind_e         br_kind;
  logic             upd_en;

  // Only the word-index bits of the PC feed the table.
  logic unused_pc;
  assign unused_pc = ^{f_pc[31:IDX_W+2], f_pc[1:0]};

  // Lookup: hash with current history (zero in bimodal mode), read registered state.
  assign f_pred_idx   = f_pc[IDX_W+1:2] ^ ghr_q;
  assign f_pred_taken = ctr_tbl[f_pred_idx][CTR_W-1];

  assign br_kind = decode_br(r_op);

  // Signed branch condition evaluation for the resolving instruction.
  always_comb begin
    r_taken = 1'b0;
    case (br_kind)
      BrEq:    r_taken = (r_a == r_b);
      BrNe:    r_taken = (r_a != r_b);
      BrGtz:   r_taken = ($signed(r_a) > 32'sd0);
      BrLez:   r_taken = ($signed(r_a) <= 32'sd0);
      BrGez:   r_taken = ~r_a[31];
      BrLtz:   r_taken = r_a[31];
      default: r_taken = 1'b0;
    endcase
  end

  assign r_is_branch  = (br_kind != BrNone);
  assign upd_en       = r_valid & r_is_branch;
  assign r_mispredict = upd_en & (r_taken != r_pred_taken);

  // One counter per table entry; only the entry named by the carried index trains.
  for (genvar i = 0; i < Depth; i++) begin : g_ctr
    logic hit;
    assign hit = upd_en & (r_pred_idx == IDX_W'(i));
    bp_sat_counter #(
      .CTR_W(CTR_W)
    ) u_ctr (
      .clk (clk),
      .rst (rst),
      .inc (hit & r_taken),
      .dec (hit & ~r_taken),
      .ctr (ctr_tbl[i])
    );
  end

  if (GSHARE) begin : g_ghr
    // Non-speculative history: shift in resolved outcomes only.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ghr_q <= '0;
      end else if (upd_en) begin
        ghr_q <= {ghr_q[IDX_W-2:0], r_taken};
      end
    end
  end else begin : g_no_ghr
    assign ghr_q = '0;
  end

  assign ghr = ghr_q;

  // Saturating mispredict counter; a clear beats a coincident increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mp_count_q <= '0;
    end else if (mp_cnt_clr) begin
      mp_count_q <= '0;
    end else if (r_mispredict && (mp_count_q != '1)) begin
      mp_count_q <= mp_count_q + CNT_W'(1);
    end
  end

  assign mp_count = mp_count_q;

endmodule

// File: tb/tb_branch_pred_resolve.sv
// Directed bench: a bimodal instance (IDX_W=6, CNT_W=4) and a gshare instance (IDX_W=4).
module tb_branch_pred_resolve;
  import branch_pred_resolve_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] f_pc;
  logic        r_valid0, r_valid1;
  logic [7:0]  r_op;
  logic [31:0] r_a, r_b;
  logic        r_pred_taken;
  logic [5:0]  r_pred_idx;
  logic        mp_cnt_clr;

  logic        f_pred_taken0, r_is_branch0, r_taken0, r_mispredict0;
  logic [5:0]  f_pred_idx0, ghr0;
  logic [3:0]  mp_count0;

  logic        f_pred_taken1, r_is_branch1, r_taken1, r_mispredict1;
  logic [3:0]  f_pred_idx1, ghr1;
  logic [15:0] mp_count1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_pred_resolve #(.IDX_W(6), .CTR_W(2), .GSHARE(1'b0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .f_pc(f_pc), .f_pred_taken(f_pred_taken0), .f_pred_idx(f_pred_idx0),
    .r_valid(r_valid0), .r_op(r_op), .r_a(r_a), .r_b(r_b), .r_pred_taken(r_pred_taken),
    .r_pred_idx(r_pred_idx), .r_is_branch(r_is_branch0), .r_taken(r_taken0),
    .r_mispredict(r_mispredict0), .ghr(ghr0), .mp_cnt_clr(mp_cnt_clr), .mp_count(mp_count0)
  );

  branch_pred_resolve #(.IDX_W(4), .CTR_W(2), .GSHARE(1'b1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .f_pc(f_pc), .f_pred_taken(f_pred_taken1), .f_pred_idx(f_pred_idx1),
    .r_valid(r_valid1), .r_op(r_op), .r_a(r_a), .r_b(r_b), .r_pred_taken(r_pred_taken),
    .r_pred_idx(r_pred_idx[3:0]), .r_is_branch(r_is_branch1), .r_taken(r_taken1),
    .r_mispredict(r_mispredict1), .ghr(ghr1), .mp_cnt_clr(mp_cnt_clr), .mp_count(mp_count1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; f_pc = '0; r_valid0 = 0; r_valid1 = 0; r_op = '0; r_a = '0; r_b = '0;
    r_pred_taken = 0; r_pred_idx = '0; mp_cnt_clr = 0;
    #12 rst = 1'b0;
    tick();

    // Reset state
    #1;
    check("rst_pred", {31'd0, f_pred_taken0}, 32'd0);
    check("rst_ctr0", {30'd0, dut0.ctr_tbl[0]}, 32'd1);
    check("rst_ctr5", {30'd0, dut0.ctr_tbl[5]}, 32'd1);
    check("rst_mp", {28'd0, mp_count0}, 32'd0);
    check("rst_ghr1", {28'd0, ghr1}, 32'd0);

    // BEQ taken three times at idx 3, predicted not-taken each time
    r_valid0 = 1; r_op = EXE_BEQ_OP; r_a = 32'd5; r_b = 32'd5; r_pred_taken = 0; r_pred_idx = 6'd3;
    f_pc = 32'h0000_000C;
    #1;
    check("beq_isbr", {31'd0, r_is_branch0}, 32'd1);
    check("beq_taken", {31'd0, r_taken0}, 32'd1);
    check("beq_mp", {31'd0, r_mispredict0}, 32'd1);
    check("beq_pre_pred", {31'd0, f_pred_taken0}, 32'd0);
    tick();
    check("beq_ctr_2", {30'd0, dut0.ctr_tbl[3]}, 32'd2);
    check("beq_pred_1", {31'd0, f_pred_taken0}, 32'd1);
    tick();
    check("beq_ctr_3", {30'd0, dut0.ctr_tbl[3]}, 32'd3);
    tick();
    check("beq_ctr_hold", {30'd0, dut0.ctr_tbl[3]}, 32'd3);
    check("beq_mpcnt", {28'd0, mp_count0}, 32'd3);

    // Signed condition corners (no update)
    r_valid0 = 0;
    r_op = EXE_BGTZ_OP; r_a = 32'd0; #1;
    check("bgtz_0", {31'd0, r_taken0}, 32'd0);
    r_op = EXE_BLEZ_OP; r_a = 32'h8000_0000; #1;
    check("blez_min", {31'd0, r_taken0}, 32'd1);
    r_op = EXE_BGEZAL_OP; r_a = 32'd0; #1;
    check("bgezal_0", {31'd0, r_taken0}, 32'd1);
    r_op = EXE_BLTZ_OP; r_a = 32'hFFFF_FFFF; #1;
    check("bltz_m1", {31'd0, r_taken0}, 32'd1);
    r_op = EXE_BNE_OP; r_a = 32'd1; r_b = 32'd2; #1;
    check("bne_diff", {31'd0, r_taken0}, 32'd1);
    r_op = EXE_BGTZ_OP; r_a = 32'h8000_0000; #1;
    check("bgtz_min", {31'd0, r_taken0}, 32'd0);

    // Non-branch op with valid: nothing changes
    r_valid0 = 1; r_valid1 = 1; r_op = EXE_ADD_OP; r_a = 32'd5; r_b = 32'd5;
    r_pred_taken = 1; r_pred_idx = 6'd3; #1;
    check("add_isbr", {31'd0, r_is_branch0}, 32'd0);
    check("add_taken", {31'd0, r_taken0}, 32'd0);
    check("add_mp", {31'd0, r_mispredict0}, 32'd0);
    tick();
    check("add_ctr", {30'd0, dut0.ctr_tbl[3]}, 32'd3);
    check("add_ctr1", {30'd0, dut1.ctr_tbl[3]}, 32'd1);
    check("add_ghr1", {28'd0, ghr1}, 32'd0);
    check("add_mpcnt", {28'd0, mp_count0}, 32'd3);
    r_valid1 = 0;

    // Same-cycle lookup and update of idx 7
    f_pc = 32'h0000_001C; r_op = EXE_BEQ_OP; r_pred_idx = 6'd7; r_pred_taken = 1; #1;
    check("byp_pre", {31'd0, f_pred_taken0}, 32'd0);
    tick();
    r_valid0 = 0;
    #1;
    check("byp_post", {31'd0, f_pred_taken0}, 32'd1);

    // Gshare history: taken, not-taken, taken
    r_valid1 = 1; r_pred_idx = 6'd0; r_pred_taken = 1;
    r_op = EXE_BEQ_OP; r_a = 32'd9; r_b = 32'd9;
    tick();
    r_op = EXE_BNE_OP;
    #1;
    check("gs_nt_mp", {31'd0, r_mispredict1}, 32'd1);
    tick();
    r_op = EXE_BEQ_OP;
    tick();
    r_valid1 = 0;
    f_pc = 32'h0000_0014;
    #1;
    check("gs_ghr", {28'd0, ghr1}, 32'd5);
    check("gs_idx", {28'd0, f_pred_idx1}, 32'd0);
    check("gs_ctr0", {30'd0, dut1.ctr_tbl[0]}, 32'd2);
    check("gs_pred", {31'd0, f_pred_taken1}, 32'd1);
    check("gs_mpcnt", {16'd0, mp_count1}, 32'd1);
    check("bim_ghr", {26'd0, ghr0}, 32'd0);

    // Mispredict counter saturation on dut0 (BNE a==b not taken, predicted taken)
    r_valid0 = 1; r_op = EXE_BNE_OP; r_a = 32'd4; r_b = 32'd4; r_pred_taken = 1;
    r_pred_idx = 6'd10;
    for (int i = 0; i < 14; i++) tick();
    check("mp_sat", {28'd0, mp_count0}, 32'd15);
    check("ctr_floor", {30'd0, dut0.ctr_tbl[10]}, 32'd0);
    mp_cnt_clr = 1;
    tick();
    mp_cnt_clr = 0;
    check("mp_clr_wins", {28'd0, mp_count0}, 32'd0);
    tick();
    check("mp_after_clr", {28'd0, mp_count0}, 32'd1);

    // Async reset in the middle of an update cycle
    r_pred_idx = 6'd3; f_pc = 32'h0000_000C;
    #2 rst = 1'b1;
    #1;
    check("arst_ctr3", {30'd0, dut0.ctr_tbl[3]}, 32'd1);
    check("arst_ctr10", {30'd0, dut0.ctr_tbl[10]}, 32'd1);
    check("arst_mp", {28'd0, mp_count0}, 32'd0);
    check("arst_ghr1", {28'd0, ghr1}, 32'd0);
    check("arst_pred", {31'd0, f_pred_taken0}, 32'd0);
    tick();
    check("arst_hold", {30'd0, dut0.ctr_tbl[3]}, 32'd1);
    r_valid0 = 0;
    #2 rst = 1'b0;
    tick();
    check("post_rst_mp", {28'd0, mp_count0}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
